// File: rtl/gemm_out_writer_if.sv
// gemm_out_writer_if: tensor-in / memory-write bundle for the GEMM output writer.
// Input side:  in_valid, in_ready, in_tensor (DEPTH lanes of ACC_WIDTH), base_addr.
// Memory side: mem_we, mem_ready, mem_addr, mem_din; status: busy, done.
// master = tensor producer + output memory (bench/system); slave = the writer.
interface gemm_out_writer_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [ACC_WIDTH*DEPTH-1:0]    in_tensor;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic                          mem_we;
  logic                          mem_ready;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [OUT_WIDTH-1:0]          mem_din;
  logic                          busy;
  logic                          done;

  modport master (
    output in_valid, in_tensor, base_addr, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_din, busy, done
  );

  modport slave (
    input  in_valid, in_tensor, base_addr, mem_ready,
    output in_ready, mem_we, mem_addr, mem_din, busy, done
  );
endinterface

// File: rtl/gemm_out_writer.sv
// gemm_out_writer: captures one accumulator tensor, narrows each lane to OUT_WIDTH
// and writes the lanes one per cycle to a single-port memory at base_addr+idx.
// Latency: accept at edge k, lane 0 on the bus right after, done one cycle after
// the last write; mem_ready=0 stalls with address/data/idx held; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (gemm_out_writer_if.slave).
// Optional macro GEMM_OUT_SAT_EN: signed saturation instead of truncation.
module gemm_out_writer #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  gemm_out_writer_if.slave   bus
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [ACC_WIDTH-1:0]    lanes [DEPTH];
  logic                    in_ready_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [OUT_WIDTH-1:0]    mem_din_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    accept;
  logic [ACC_WIDTH-1:0]    lane0_in;

`ifdef GEMM_OUT_SAT_EN
  // Signed range limits of an OUT_WIDTH word, sign-extended to ACC_WIDTH.
  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] r;
    if ($signed(v) > $signed(SAT_MAX)) begin
      r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if ($signed(v) < $signed(SAT_MIN)) begin
      r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      r = v[OUT_WIDTH-1:0];
    end
    return r;
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] v);
    return v[OUT_WIDTH-1:0];
  endfunction

  // Truncation never looks at the upper lane bits; fold them away so the
  // holding register keeps its full accumulator width without lint noise.
  logic lanes_hi_unused;
  always_comb begin
    lanes_hi_unused = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      lanes_hi_unused = lanes_hi_unused ^ (^lanes[i]);
    end
  end
`endif

  // in_ready_q is only ever 1 in IDLE, so it alone qualifies the handshake.
  assign accept   = (state == IDLE) && bus.in_valid && in_ready_q;
  assign lane0_in = bus.in_tensor[ACC_WIDTH-1:0];
  assign idx_nxt  = idx + 1'b1;

  // Holding register: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        lanes[i] <= bus.in_tensor[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Control FSM with every output registered. mem_din is preloaded with the
  // next lane on each completion so the memory bus never sees a decode path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            idx        <= '0;
            mem_addr_q <= bus.base_addr;
            mem_din_q  <= narrow(lane0_in);
            mem_we_q   <= 1'b1;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            if (idx == LAST_IDX) begin
              mem_we_q <= 1'b0;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              idx        <= idx_nxt;
              mem_addr_q <= mem_addr_q + 1'b1;  // silent wrap
              mem_din_q  <= narrow(lanes[idx_nxt]);
            end
          end
        end
        DONE: begin
          // No re-accept here; in_ready rises on the way back to IDLE.
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          mem_we_q   <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_gemm_out_writer.sv
// tb_gemm_out_writer: directed test of gemm_out_writer with a write monitor.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Expected values are hand-computed; saturation expectations follow GEMM_OUT_SAT_EN.
module tb_gemm_out_writer;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int D   = 16;
  localparam int ADW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gemm_out_writer_if #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .DEPTH(D), .ADDR_WIDTH(ADW)) bus ();

  gemm_out_writer #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .DEPTH(D), .ADDR_WIDTH(ADW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         stall_bad = 0;
  logic       ready_at_done = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_addr = '0;
  logic [7:0] prev_din = '0;

  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ready) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_din);
      wr_cyc.push_back(cyc);
    end
    if (prev_stall && bus.mem_we && (bus.mem_addr !== prev_addr || bus.mem_din !== prev_din))
      stall_bad++;
    prev_stall = bus.mem_we && !bus.mem_ready;
    prev_addr  = bus.mem_addr;
    prev_din   = bus.mem_din;
    if (bus.done) begin
      done_cnt++;
      done_cyc      = cyc;
      ready_at_done = bus.in_ready;
    end
  end

  // mem_ready driver: mode 0 = always ready, mode 1 = toggle every cycle.
  int rdy_mode = 0;
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.mem_ready = ~bus.mem_ready;
      else               bus.mem_ready = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [AW*D-1:0] mk_inc(input int start);
    logic [AW*D-1:0] t;
    t = '0;
    for (int i = 0; i < D; i++) t[i*AW +: AW] = AW'(start + i);
    return t;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    stall_bad = 0;
  endtask

  // Called 1 unit after a rising edge; k = edge number at which the accept occurs.
  task automatic send(input logic [AW*D-1:0] t, input logic [7:0] base, output int k);
    int n;
    n = 0;
    k = -1;
    bus.in_tensor = t;
    bus.base_addr = base;
    bus.in_valid  = 1'b1;
    while (k < 0 && n < 100) begin
      if (bus.in_ready) k = cyc + 1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.in_tensor = '1;  // captured copy must not follow the input
    if (k < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
  endtask

  // ---------------- stimulus ----------------
  logic [AW*D-1:0] ta, tb_t, tc, tn;
  logic [7:0]      exp_n [5];
  int              k, k1, k2, d0, n;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_tensor = '0;
    bus.base_addr = '0;
    ta   = mk_inc(1);
    tb_t = mk_inc(8'h40);
    tc   = '0;
    for (int i = 0; i < D; i++) tc[i*AW +: AW] = 32'h99;

    // Reset values
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din",  bus.mem_din,  0);
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // 1: base 0x10, mem_ready=1, lanes 1..16
    clear_log();
    send(ta, 8'h10, k);
    wait_done(1);
    check("t1_count", wr_addr.size(), 16);
    for (int i = 0; i < D && i < wr_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), wr_addr[i], 8'h10 + i);
      check($sformatf("t1_data%0d", i), wr_data[i], i + 1);
      check($sformatf("t1_cyc%0d", i),  wr_cyc[i],  k + i);
    end
    // done in cycle k+17, i.e. sampled between edges k+16 and k+17
    check("t1_done_cyc", done_cyc, k + 16);
    check("t1_ready_at_done", ready_at_done, 0);

    // 2: mem_ready toggling
    rdy_mode = 1;
    clear_log();
    send(ta, 8'h10, k);
    wait_done(2);
    rdy_mode = 0;
    check("t2_count", wr_addr.size(), 16);
    for (int i = 0; i < D && i < wr_addr.size(); i++) begin
      check($sformatf("t2_addr%0d", i), wr_addr[i], 8'h10 + i);
      check($sformatf("t2_data%0d", i), wr_data[i], i + 1);
    end
    check("t2_stall_stable", stall_bad, 0);
    check("t2_done_cnt", done_cnt, 2);

    // 3: address wrap from 0xF8
    @(posedge clk);
    #1;
    clear_log();
    send(ta, 8'hF8, k);
    wait_done(3);
    check("t3_count", wr_addr.size(), 16);
    for (int i = 0; i < D && i < wr_addr.size(); i++) begin
      check($sformatf("t3_addr%0d", i), wr_addr[i], (i < 8) ? (8'hF8 + i) : (i - 8));
    end

    // 4: narrowing
    tn = '0;
    tn[0*AW +: AW] = 32'h0000_0123;
    tn[1*AW +: AW] = 32'hFFFF_FF00;
    tn[2*AW +: AW] = 32'h0000_007F;
    tn[3*AW +: AW] = 32'hFFFF_FF80;
    tn[4*AW +: AW] = 32'h0000_0080;
`ifdef GEMM_OUT_SAT_EN
    exp_n[0] = 8'h7F; exp_n[1] = 8'h80; exp_n[2] = 8'h7F; exp_n[3] = 8'h80; exp_n[4] = 8'h7F;
`else
    exp_n[0] = 8'h23; exp_n[1] = 8'h00; exp_n[2] = 8'h7F; exp_n[3] = 8'h80; exp_n[4] = 8'h80;
`endif
    clear_log();
    send(tn, 8'h00, k);
    wait_done(4);
    for (int i = 0; i < 5 && i < wr_data.size(); i++) begin
      check($sformatf("t4_narrow%0d", i), wr_data[i], exp_n[i]);
    end
    check("t4_count", wr_data.size(), 16);

    // 5: in_valid held high with a changing tensor
    clear_log();
    d0 = done_cnt;
    bus.base_addr = 8'h20;
    bus.in_tensor = ta;
    bus.in_valid  = 1'b1;
    k1 = -1;
    n  = 0;
    while (k1 < 0 && n < 50) begin
      if (bus.in_ready) k1 = cyc + 1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_tensor = tb_t;
    k2 = -1;
    n  = 0;
    while (k2 < 0 && n < 50) begin
      if (bus.in_ready) k2 = cyc + 1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_tensor = tc;
    bus.in_valid  = 1'b0;
    wait_done(d0 + 2);
    check("t5_accept_gap", k2 - k1, D + 2);
    check("t5_ready_at_done", ready_at_done, 0);
    check("t5_count", wr_data.size(), 32);
    for (int i = 0; i < D && (16 + i) < wr_data.size(); i++) begin
      check($sformatf("t5_second%0d", i), wr_data[16 + i], 8'h40 + i);
    end

    // 6: async reset during lane 5
    clear_log();
    d0 = done_cnt;
    send(ta, 8'h10, k);
    repeat (5) @(posedge clk);
    #1;
    check("t6_lane5_addr", bus.mem_addr, 8'h15);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_we", bus.mem_we, 0);
    check("t6_async_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_partial_count", wr_addr.size(), 5);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_in_ready", bus.in_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, d0);
    clear_log();
    send(ta, 8'h10, k);
    wait_done(d0 + 1);
    check("t6_new_count", wr_addr.size(), 16);
    if (wr_addr.size() > 0) begin
      check("t6_new_addr0", wr_addr[0], 8'h10);
      check("t6_new_data0", wr_data[0], 8'h01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
